// File: rtl/game_ctrl_if.sv
// Game sequencer signal bundle: player/timer inputs and game state outputs.
// The master modport belongs to game_ctrl; the slave modport is the consumer side.
interface game_ctrl_if;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned TIME_W  = 16;
  localparam int unsigned SCORE_W = 8;

  logic               mouse_left;
  logic               clicked_duck;
  logic               end_of_time;
  logic [STATE_W-1:0] state_out;
  logic [TIME_W-1:0]  time_out;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic               new_record;

  modport master (
    input  mouse_left, clicked_duck, end_of_time,
    output state_out, time_out, score, high_score, new_record
  );

  modport slave (
    output mouse_left, clicked_duck, end_of_time,
    input  state_out, time_out, score, high_score, new_record
  );
endinterface

// File: rtl/game_ctrl.sv
// Top-level game sequencer feeding game_timer: START -> GAME -> SCORE -> START.
// Counts duck hits, shortens the per-duck time limit every HITS_PER_LEVEL hits,
// and enforces a minimum SCORE dwell before a click returns to START.
// Optional high-score tracking is built only when GAME_CTRL_HIGH_SCORE_EN is defined.
module game_ctrl #(
  parameter logic [15:0] INIT_TIME      = 16'd5,
  parameter logic [15:0] MIN_TIME       = 16'd1,
  parameter logic [3:0]  HITS_PER_LEVEL = 4'd5,
  parameter logic [23:0] HOLD_CYCLES    = 24'd7_500_000
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.master bus
);

  localparam int unsigned TIME_W  = 16;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned HOLD_W  = 24;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_SCORE = 2'b01,
    ST_GAME  = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 mouse_q, mouse_d;
  logic                 duck_q, duck_d;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [SCORE_W-1:0]   high_q, high_d;
  logic                 record_q, record_d;
`endif

  logic                 click_rise_c;
  logic                 hit_rise_c;
  logic [LEVEL_W-1:0]   level_inc_c;

  assign click_rise_c = bus.mouse_left & ~mouse_q;
  assign hit_rise_c   = bus.clicked_duck & ~duck_q;
  assign level_inc_c  = level_q + LEVEL_W'(1);

  // Next-state and next-output computation for every register.
  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    score_d  = score_q;
    level_d  = level_q;
    hold_d   = hold_q;
    mouse_d  = bus.mouse_left;
    duck_d   = bus.clicked_duck;
`ifdef GAME_CTRL_HIGH_SCORE_EN
    high_d   = high_q;
    record_d = record_q;
`endif

    case (state_q)
      ST_START: begin
        if (click_rise_c) begin
          state_d  = ST_GAME;
          score_d  = '0;
          time_d   = INIT_TIME;
          level_d  = '0;
`ifdef GAME_CTRL_HIGH_SCORE_EN
          record_d = 1'b0;
`endif
        end
      end

      ST_GAME: begin
        // Time-out wins over a simultaneous hit; that hit is dropped.
        if (bus.end_of_time) begin
          state_d = ST_SCORE;
          hold_d  = '0;
`ifdef GAME_CTRL_HIGH_SCORE_EN
          if (score_q > high_q) begin
            high_d   = score_q;
            record_d = 1'b1;
          end
`endif
        end else if (hit_rise_c) begin
          if (score_q != {SCORE_W{1'b1}}) begin
            score_d = score_q + SCORE_W'(1);
          end
          if (level_inc_c == HITS_PER_LEVEL) begin
            level_d = '0;
            time_d  = (time_q > MIN_TIME) ? time_q - TIME_W'(1) : MIN_TIME;
          end else begin
            level_d = level_inc_c;
          end
        end
      end

      ST_SCORE: begin
        if (hold_q != HOLD_CYCLES) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        // Early clicks are simply lost, not remembered for later.
        if (click_rise_c && (hold_q == HOLD_CYCLES)) begin
          state_d = ST_START;
        end
      end

      default: begin
        state_d = ST_START;
        score_d = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_START;
      time_q   <= INIT_TIME;
      score_q  <= '0;
      level_q  <= '0;
      hold_q   <= '0;
      mouse_q  <= 1'b0;
      duck_q   <= 1'b0;
`ifdef GAME_CTRL_HIGH_SCORE_EN
      high_q   <= '0;
      record_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      score_q  <= score_d;
      level_q  <= level_d;
      hold_q   <= hold_d;
      mouse_q  <= mouse_d;
      duck_q   <= duck_d;
`ifdef GAME_CTRL_HIGH_SCORE_EN
      high_q   <= high_d;
      record_q <= record_d;
`endif
    end
  end

  assign bus.state_out = state_q;
  assign bus.time_out  = time_q;
  assign bus.score     = score_q;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  assign bus.high_score = high_q;
  assign bus.new_record = record_q;
`else
  assign bus.high_score = '0;
  assign bus.new_record = 1'b0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl against a rule-level reference model.
// Expected time limit is derived from total hits in the game, not a level counter.
module tb_game_ctrl;

  localparam int HOLD = 100;
  localparam int INIT = 5;
  localparam int MINT = 1;
  localparam int HPL  = 5;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  game_ctrl_if bus ();

  game_ctrl #(
    .INIT_TIME      (16'd5),
    .MIN_TIME       (16'd1),
    .HITS_PER_LEVEL (4'd5),
    .HOLD_CYCLES    (24'd100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [1:0] m_state;
  int         m_score;
  int         m_high;
  bit         m_rec;
  int         m_hits;
  int         m_sc;
  bit         m_ml_q;
  bit         m_cd_q;

  task automatic model_reset();
    m_state = 2'b00; m_score = 0; m_high = 0; m_rec = 1'b0;
    m_hits = 0; m_sc = 0; m_ml_q = 1'b0; m_cd_q = 1'b0;
  endtask

  task automatic model_step(input bit ml, input bit cd, input bit eot);
    bit click;
    bit hit;
    click = ml && !m_ml_q;
    hit   = cd && !m_cd_q;
    if (m_state == 2'b00) begin
      if (click) begin
        m_state = 2'b10; m_score = 0; m_hits = 0; m_rec = 1'b0;
      end
    end else if (m_state == 2'b10) begin
      if (eot) begin
        m_state = 2'b01; m_sc = 0;
        if (HS_EN && m_score > m_high) begin
          m_high = m_score; m_rec = 1'b1;
        end
      end else if (hit) begin
        m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
        m_hits++;
      end
    end else if (m_state == 2'b01) begin
      if (click && m_sc >= HOLD) m_state = 2'b00;
      m_sc++;
    end
    m_ml_q = ml;
    m_cd_q = cd;
  endtask

  function automatic logic [42:0] exp_vec();
    int t;
    t = INIT - m_hits / HPL;
    if (t < MINT) t = MINT;
    return {m_state, 16'(t), 8'(m_score), 8'(m_high), m_rec};
  endfunction

  function automatic logic [42:0] act_vec();
    return {bus.state_out, bus.time_out, bus.score, bus.high_score, bus.new_record};
  endfunction

  // One clock: drive inputs, advance model on the edge, sample 1 time unit later.
  task automatic step(input bit ml, input bit cd, input bit eot);
    bus.mouse_left   = ml;
    bus.clicked_duck = cd;
    bus.end_of_time  = eot;
    @(posedge clk);
    model_step(ml, cd, eot);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mouse_left = 1'b0; bus.clicked_duck = 1'b0; bus.end_of_time = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic hit_pulses(input int n, input int hi, input int lo, input string tag);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < hi + lo; k++) begin
        step(1'b0, (k < hi), 1'b0);
        checks++;
        if (act_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL %s hit %0d: got st/time/score/high/rec=%h expected %h", tag, i, act_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (act_vec() !== {2'b00, 16'd5, 8'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", act_vec(), {2'b00, 16'd5, 8'd0, 8'd0, 1'b0});
    end
  endtask

  task automatic test_start();
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.state_out !== 2'b00) begin
      errors++;
      $display("FAIL start_ignores_hit: got state %b expected 00", bus.state_out);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.state_out, bus.score, bus.time_out} !== {2'b10, 8'd0, 16'd5}) begin
      errors++;
      $display("FAIL start_click: got state %b score %0d time %0d expected 10/0/5",
               bus.state_out, bus.score, bus.time_out);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_levels();
    hit_pulses(5, 3, 2, "level1");
    checks++;
    if ({bus.score, bus.time_out} !== {8'd5, 16'd4}) begin
      errors++;
      $display("FAIL five_hits: got score %0d time %0d expected 5/4", bus.score, bus.time_out);
    end
    hit_pulses(25, 1, 1, "level_clamp");
    checks++;
    if ({bus.score, bus.time_out} !== {8'd30, 16'd1}) begin
      errors++;
      $display("FAIL clamp_min_time: got score %0d time %0d expected 30/1", bus.score, bus.time_out);
    end
  endtask

  task automatic test_eot_priority();
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (act_vec() !== {2'b01, 16'd1, 8'd30, (HS_EN ? 8'd30 : 8'd0), HS_EN}) begin
      errors++;
      $display("FAIL eot_over_hit: got %h expected %h", act_vec(),
               {2'b01, 16'd1, 8'd30, (HS_EN ? 8'd30 : 8'd0), HS_EN});
    end
  endtask

  task automatic test_hold();
    for (int i = 1; i <= 155; i++) begin
      step((i == 10) || (i == 150), 1'b0, 1'b0);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hold_cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (i == 12) begin
        checks++;
        if (bus.state_out !== 2'b01) begin
          errors++;
          $display("FAIL early_click: got state %b expected 01", bus.state_out);
        end
      end
      if (i == 150) begin
        checks++;
        if ({bus.state_out, bus.score} !== {2'b00, 8'd30}) begin
          errors++;
          $display("FAIL late_click: got state %b score %0d expected 00/30", bus.state_out, bus.score);
        end
      end
    end
  endtask

  task automatic test_high_score();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    hit_pulses(7, 2, 2, "game7");
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.score, bus.high_score, bus.new_record} !== {8'd7, (HS_EN ? 8'd7 : 8'd0), HS_EN}) begin
      errors++;
      $display("FAIL first_game_record: got score %0d high %0d rec %b", bus.score, bus.high_score, bus.new_record);
    end
    for (int i = 0; i < HOLD + 1; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus.state_out, bus.score, bus.new_record} !== {2'b10, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL second_game_start: got state %b score %0d rec %b expected 10/0/0",
               bus.state_out, bus.score, bus.new_record);
    end
    hit_pulses(3, 1, 3, "game3");
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if ({bus.state_out, bus.score, bus.high_score, bus.new_record} !==
        {2'b01, 8'd3, (HS_EN ? 8'd7 : 8'd0), 1'b0}) begin
      errors++;
      $display("FAIL second_game_no_record: got state %b score %0d high %0d rec %b",
               bus.state_out, bus.score, bus.high_score, bus.new_record);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    hit_pulses(260, 1, 1, "saturate");
    checks++;
    if ({bus.score, bus.time_out} !== {8'd255, 16'd1}) begin
      errors++;
      $display("FAIL score_saturate: got score %0d time %0d expected 255/1", bus.score, bus.time_out);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (act_vec() !== {2'b00, 16'd5, 8'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", act_vec(), {2'b00, 16'd5, 8'd0, 8'd0, 1'b0});
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_random();
    bit ml;
    bit cd;
    bit eot;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ml  = ($urandom_range(0, 3) == 0);
      cd  = ($urandom_range(0, 2) == 0);
      eot = ($urandom_range(0, 39) == 0);
      step(ml, cd, eot);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.mouse_left = 1'b0; bus.clicked_duck = 1'b0; bus.end_of_time = 1'b0;
    model_reset();
    test_reset();
    test_start();
    test_levels();
    test_eot_priority();
    test_hold();
    test_high_score();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
